nco_sweep_ctrl: RTL and testbench



---
 rtl/nco_ctrl_pkg.sv | 12 +
 rtl/nco_step_clamp.sv | 41 ++++
 rtl/nco_sweep_ctrl.sv | 99 +++++++++
 tb/tb_nco_sweep_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// rtl/nco_ctrl_pkg.sv - shared state encoding and default widths for the NCO sweep controller
package nco_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int PHASE_INC_BITS = 40;
  localparam int DWELL_BITS     = 16;

endpackage

// File: rtl/nco_step_clamp.sv
// rtl/nco_step_clamp.sv - one ramp step toward target, clamped so it never overshoots
module nco_step_clamp #(
  parameter int W = 40
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  output logic [W-1:0] next,
  output logic         at_target
);

  logic [W-1:0] diff;

  // Subtract only in the direction known to be non-negative; cur+step cannot wrap
  // because it is used only when it stays strictly below target.
  always_comb begin
    next      = cur;
    at_target = 1'b0;
    diff      = '0;
    if (target > cur) begin
      diff = target - cur;
      if (diff <= step) begin
        next      = target;
        at_target = 1'b1;
      end else begin
        next = cur + step;
      end
    end else if (target < cur) begin
      diff = cur - target;
      if (diff <= step) begin
        next      = target;
        at_target = 1'b1;
      end else begin
        next = cur - step;
      end
    end else begin
      at_target = 1'b1;
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - accepts tuning commands and jumps or ramps the NCO phase_inc word
module nco_sweep_ctrl #(
  parameter int PHASE_INC_BITS = nco_ctrl_pkg::PHASE_INC_BITS,
  parameter int DWELL_BITS     = nco_ctrl_pkg::DWELL_BITS,
  parameter logic [PHASE_INC_BITS-1:0] INIT_PHASE_INC = '0
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [PHASE_INC_BITS-1:0] cmd_target,
  input  logic [PHASE_INC_BITS-1:0] cmd_step,
  input  logic [DWELL_BITS-1:0]     cmd_dwell,
  input  logic                      cmd_phase_reset,
  input  logic                      abort,
  output logic [PHASE_INC_BITS-1:0] phase_inc,
  output logic                      nco_rstb,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted
);
  import nco_ctrl_pkg::*;

  state_t                    state, state_next;
  logic [DWELL_BITS-1:0]     cnt, dwell_q;
  logic [PHASE_INC_BITS-1:0] target_q, step_q, step_next;
  logic                      step_at_target;
  logic                      accept, is_jump, step_due, do_abort;

  nco_step_clamp #(.W(PHASE_INC_BITS)) u_clamp (
    .cur       (phase_inc),
    .target    (target_q),
    .step      (step_q),
    .next      (step_next),
    .at_target (step_at_target)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    is_jump    = 1'b0;
    step_due   = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        accept  = cmd_valid;
        is_jump = (cmd_step == '0) || (cmd_target == phase_inc);
        if (accept && !is_jump) state_next = RUN;
      end
      RUN: begin
        // Abort wins over a step falling due on the same edge.
        do_abort = abort;
        step_due = !abort && (cnt == '0);
        if (do_abort || (step_due && step_at_target)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      phase_inc <= INIT_PHASE_INC;
      nco_rstb  <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cnt       <= '0;
      target_q  <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
    end else begin
      nco_rstb <= !(accept && cmd_phase_reset);
      done     <= (accept && is_jump) || (step_due && step_at_target);
      aborted  <= do_abort;
      if (accept) begin
        target_q <= cmd_target;
        step_q   <= cmd_step;
        dwell_q  <= cmd_dwell;
        if (is_jump) phase_inc <= cmd_target;
        else         cnt       <= cmd_dwell;
      end else if (state == RUN && !do_abort) begin
        if (step_due) begin
          phase_inc <= step_next;
          cnt       <= dwell_q;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed bench for nco_sweep_ctrl with hand-computed expectations
module tb_nco_sweep_ctrl;

  localparam int W = 40;
  localparam int D = 16;

  logic         CLK = 1'b0;
  logic         RSTb = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_target = '0;
  logic [W-1:0] cmd_step = '0;
  logic [D-1:0] cmd_dwell = '0;
  logic         cmd_phase_reset = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] phase_inc;
  logic         nco_rstb, busy, done, aborted;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  nco_sweep_ctrl dut (
    .CLK             (CLK),
    .RSTb            (RSTb),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_target      (cmd_target),
    .cmd_step        (cmd_step),
    .cmd_dwell       (cmd_dwell),
    .cmd_phase_reset (cmd_phase_reset),
    .abort           (abort),
    .phase_inc       (phase_inc),
    .nco_rstb        (nco_rstb),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] t, input logic [W-1:0] s, input logic [D-1:0] d, input logic pr);
    cmd_valid       = 1'b1;
    cmd_target      = t;
    cmd_step        = s;
    cmd_dwell       = d;
    cmd_phase_reset = pr;
    tick();
    cmd_valid       = 1'b0;
    cmd_phase_reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] e;

    #12;
    chk("rst_phase_inc", phase_inc, '0);
    chk("rst_nco_rstb", W'(nco_rstb), W'(1));
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_aborted", W'(aborted), '0);
    chk("rst_ready", W'(cmd_ready), W'(1));
    RSTb = 1'b1;
    tick();

    // jump
    send(40'h10_0000_0000, '0, '0, 1'b0);
    chk("jump_phase_inc", phase_inc, 40'h10_0000_0000);
    chk("jump_done", W'(done), W'(1));
    chk("jump_busy", W'(busy), '0);
    chk("jump_ready", W'(cmd_ready), W'(1));
    tick();
    chk("jump_done_clr", W'(done), '0);

    // ramp up 0 -> 1000, step 300, dwell 2
    send('0, '0, '0, 1'b0);
    tick();
    send(W'(1000), W'(300), D'(2), 1'b0);
    chk("up_busy", W'(busy), W'(1));
    chk("up_ready", W'(cmd_ready), '0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k == 12) ? W'(1000) : W'((k / 3) * 300);
      chk($sformatf("up_pi_%0d", k), phase_inc, e);
      chk($sformatf("up_done_%0d", k), W'(done), W'(k == 12));
    end
    chk("up_ready_back", W'(cmd_ready), W'(1));
    chk("up_busy_clr", W'(busy), '0);

    // ramp down 1000 -> 50, step 400, dwell 0
    send(W'(50), W'(400), D'(0), 1'b0);
    chk("dn_hold", phase_inc, W'(1000));
    tick();
    chk("dn_1", phase_inc, W'(600));
    tick();
    chk("dn_2", phase_inc, W'(200));
    tick();
    chk("dn_3", phase_inc, W'(50));
    chk("dn_done", W'(done), W'(1));
    tick();
    chk("dn_stay", phase_inc, W'(50));
    chk("dn_done_clr", W'(done), '0);

    // saturation near the top of the range
    send(40'hFF_FFFF_FFF6, '0, '0, 1'b0);
    tick();
    send(40'hFF_FFFF_FFFF, 40'h80_0000_0000, D'(0), 1'b0);
    chk("sat_hold", phase_inc, 40'hFF_FFFF_FFF6);
    tick();
    chk("sat_pi", phase_inc, 40'hFF_FFFF_FFFF);
    chk("sat_done", W'(done), W'(1));
    chk("sat_busy", W'(busy), '0);

    // abort on the edge of the second step
    tick();
    send('0, '0, '0, 1'b0);
    tick();
    send(W'(1000), W'(300), D'(2), 1'b0);
    for (int k = 1; k <= 5; k++) tick();
    chk("ab_pre", phase_inc, W'(300));
    abort = 1'b1;
    tick();
    chk("ab_pi", phase_inc, W'(300));
    chk("ab_aborted", W'(aborted), W'(1));
    chk("ab_done", W'(done), '0);
    chk("ab_ready", W'(cmd_ready), W'(1));

    // abort held high in IDLE with a phase-reset jump on the next edge
    send(W'(77), '0, '0, 1'b1);
    chk("pr_pi", phase_inc, W'(77));
    chk("pr_rstb_low", W'(nco_rstb), '0);
    chk("pr_done", W'(done), W'(1));
    chk("pr_aborted", W'(aborted), '0);
    abort = 1'b0;
    tick();
    chk("pr_rstb_high", W'(nco_rstb), W'(1));

    // async reset in the middle of a ramp
    send(W'(1000), W'(300), D'(0), 1'b0);
    tick();
    chk("mr_pi", phase_inc, W'(377));
    chk("mr_busy", W'(busy), W'(1));
    #2 RSTb = 1'b0;
    #1;
    chk("mr_rst_pi", phase_inc, '0);
    chk("mr_rst_busy", W'(busy), '0);
    chk("mr_rst_ready", W'(cmd_ready), W'(1));
    #1 RSTb = 1'b1;
    tick();
    chk("mr_after", phase_inc, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
